// File: rtl/joy_db15_scanner.sv
// joy_db15_scanner: scans two 16-button pads on a 32-bit '165 shift-register chain.
// Ports:
//    clk        - system clock
//    RESET_N    - asynchronous active-low reset
//    JOY_DATA   - serial data from the chain, low = pressed
//    JOY_CLK    - registered shift clock to the chain
//    JOY_LOAD   - registered active-low parallel load to the chain
//    joystick1  - player 1 buttons (raw[15:0] inverted), active-high
//    joystick2  - player 2 buttons (raw[31:16] inverted), active-high
//    frame_stb  - one-cycle pulse in the cycle joystick1/joystick2 take new values
module joy_db15_scanner #(
   parameter int CLK_DIV   = 50,
   parameter int FRAME_GAP = 1000
) (
   input  logic        clk,
   input  logic        RESET_N,
   input  logic        JOY_DATA,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_stb
);

   typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_PUBLISH, S_GAP} state_t;

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] slot_q, slot_d;
   logic [4:0]  idx_q, idx_d;
   logic        phase_q, phase_d;
   logic [31:0] raw_q, raw_d;
   logic [1:0]  sync_q;
   logic        jclk_q, jclk_d;
   logic        jload_q, jload_d;
   logic [15:0] j1_q, j1_d;
   logic [15:0] j2_q, j2_d;
   logic        stb_q, stb_d;
   logic        tick;
   logic        gap_done;

   // An all-zero player field means nothing is plugged in, so report no buttons.
   function automatic logic [15:0] player(input logic [15:0] r);
      return (r == 16'h0000) ? 16'h0000 : ~r;
   endfunction

   assign JOY_CLK   = jclk_q;
   assign JOY_LOAD  = jload_q;
   assign joystick1 = j1_q;
   assign joystick2 = j2_q;
   assign frame_stb = stb_q;

   always_comb begin
      // The divider freezes during the single PUBLISH cycle, stretching the frame by one clk.
      tick     = (state_q != S_PUBLISH) && (div_q == 16'(CLK_DIV - 1));
      div_d    = (state_q == S_PUBLISH) ? div_q : (tick ? 16'd0 : div_q + 16'd1);
      gap_done = ({1'b0, slot_q} + 17'd1) >= 17'(FRAME_GAP);
      state_d  = state_q;
      slot_d   = slot_q;
      idx_d    = idx_q;
      phase_d  = phase_q;
      raw_d    = raw_q;
      jclk_d   = jclk_q;
      jload_d  = jload_q;
      j1_d     = j1_q;
      j2_d     = j2_q;
      stb_d    = 1'b0;
      case (state_q)
         // slot_q counts load ticks already driven low; coming out of reset it starts at 0
         // so the first tick after release is the first low-load tick.
         S_LOAD: if (tick) begin
            if (slot_q == 16'd2) begin
               state_d = S_SHIFT;
               slot_d  = '0;
               idx_d   = '0;
               phase_d = 1'b0;
               jclk_d  = 1'b0;
               jload_d = 1'b1;
            end else begin
               slot_d  = slot_q + 16'd1;
               jload_d = 1'b0;
               jclk_d  = 1'b1;
            end
         end
         S_SHIFT: if (tick) begin
            if (!phase_q) begin
               raw_d[idx_q] = sync_q[1];
               phase_d      = 1'b1;
               jclk_d       = 1'b1;
            end else if (idx_q == 5'd31) begin
               state_d = S_PUBLISH;
               phase_d = 1'b0;
               j1_d    = player(raw_q[15:0]);
               j2_d    = player(raw_q[31:16]);
               stb_d   = 1'b1;
            end else begin
               idx_d   = idx_q + 5'd1;
               phase_d = 1'b0;
               jclk_d  = 1'b0;
            end
         end
         S_PUBLISH: begin
            state_d = S_GAP;
            slot_d  = '0;
         end
         S_GAP: if (tick) begin
            if (gap_done) begin
               state_d = S_LOAD;
               slot_d  = 16'd1;
               jload_d = 1'b0;
            end else begin
               slot_d = slot_q + 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_LOAD;
         div_q   <= '0;
         slot_q  <= '0;
         idx_q   <= '0;
         phase_q <= 1'b0;
         raw_q   <= '0;
         sync_q  <= '0;
         jclk_q  <= 1'b1;
         jload_q <= 1'b1;
         j1_q    <= '0;
         j2_q    <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         slot_q  <= slot_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         raw_q   <= raw_d;
         sync_q  <= {sync_q[0], JOY_DATA};
         jclk_q  <= jclk_d;
         jload_q <= jload_d;
         j1_q    <= j1_d;
         j2_q    <= j2_d;
         stb_q   <= stb_d;
      end
   end

endmodule

// File: tb/tb_joy_db15_scanner.sv
// tb_joy_db15_scanner: randomized frames against a cycle-position model of the scanner.
module tb_joy_db15_scanner;

   localparam int CD = 4;
   localparam int FG = 2;
   localparam int LE = 2 * CD;
   localparam int SE = (2 + 64) * CD;
   localparam int FP = (66 + FG) * CD + 1;

   logic        clk = 1'b0;
   logic        RESET_N = 1'b0;
   logic        JOY_DATA = 1'b1;
   logic        JOY_CLK, JOY_LOAD, frame_stb;
   logic [15:0] joystick1, joystick2;

   int          tests = 0;
   int          fails = 0;
   int          t;
   int          p;
   logic [31:0] pat = 32'hFFFF_FFFF;
   logic [31:0] fpat = 32'hFFFF_FFFF;
   logic [31:0] sr = 32'hFFFF_FFFF;
   logic        pclk = 1'b1;
   logic [15:0] exp_j1 = '0, exp_j2 = '0, pj1 = '0, pj2 = '0;
   logic        e_clk, e_load, e_stb;

   always #5 clk = ~clk;

   joy_db15_scanner #(.CLK_DIV(CD), .FRAME_GAP(FG)) dut (
      .clk(clk), .RESET_N(RESET_N), .JOY_DATA(JOY_DATA), .JOY_CLK(JOY_CLK),
      .JOY_LOAD(JOY_LOAD), .joystick1(joystick1), .joystick2(joystick2), .frame_stb(frame_stb)
   );

   function automatic logic [15:0] player(input logic [15:0] r);
      return (r == 16'h0000) ? 16'h0000 : ~r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   always @(posedge clk or negedge RESET_N)
      if (!RESET_N) t <= 0;
      else t <= t + 1;

   // '165 chain: parallel load while JOY_LOAD low, shift on JOY_CLK rising edge.
   always @(negedge clk) begin
      if (!JOY_LOAD) sr = pat;
      else if (JOY_CLK && !pclk) sr = {1'b1, sr[31:1]};
      pclk = JOY_CLK;
      JOY_DATA = sr[0];
   end

   // Expected outputs from the position of the cycle inside the frame.
   always @(negedge clk) begin
      if (!RESET_N) begin
         exp_j1 = '0; exp_j2 = '0; e_clk = 1'b1; e_load = 1'b1; e_stb = 1'b0;
      end else if (t < CD) begin
         e_clk = 1'b1; e_load = 1'b1; e_stb = 1'b0;
      end else begin
         p = (t - CD) % FP;
         if (p == 0) fpat = pat;
         e_load = (p >= LE);
         e_clk  = (p >= LE && p < SE) ? ((((p - LE) / CD) % 2) == 1) : 1'b1;
         e_stb  = (p == SE);
         if (e_stb) begin
            exp_j1 = player(fpat[15:0]);
            exp_j2 = player(fpat[31:16]);
         end
      end
      chk("model", {29'd0, joystick1, joystick2, JOY_CLK, JOY_LOAD, frame_stb},
          {29'd0, exp_j1, exp_j2, e_clk, e_load, e_stb});
      if (RESET_N) begin
         tests++;
         assert (frame_stb || (joystick1 == pj1 && joystick2 == pj2)) else begin
            fails++;
            $display("FAIL atomic: outputs %h/%h changed from %h/%h without frame_stb",
                     joystick1, joystick2, pj1, pj2);
         end
      end
      pj1 = joystick1;
      pj2 = joystick2;
   end

   task automatic wait_stb();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_stb && n < 2 * FP);
      chk("stb_seen", {63'd0, frame_stb}, 64'd1);
   endtask

   task automatic rand_pat();
      logic [31:0] r;
      int          s;
      r = $urandom;
      s = $urandom_range(0, 3);
      if (s == 0) r[15:0] = '0;
      if (s == 1) r[31:16] = '0;
      pat = r;
   endtask

   initial begin
      int per, lowload, run, pulses, badw, falls;
      logic pc;
      pat = ~((32'd1 << 0) | (32'd1 << 20));
      repeat (10) @(negedge clk);
      chk("reset_outs", {29'd0, joystick1, joystick2, JOY_CLK, JOY_LOAD, frame_stb},
          {29'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0});
      @(posedge clk); #2 RESET_N = 1'b1;
      wait_stb();
      chk("pattern_j1", {48'd0, joystick1}, 64'h0001);
      chk("pattern_j2", {48'd0, joystick2}, 64'h0010);
      rand_pat();
      per = 0; lowload = 0; run = 0; pulses = 0; badw = 0;
      do begin
         @(negedge clk);
         per++;
         if (per == 1) chk("stb_width", {63'd0, frame_stb}, 64'd0);
         if (!JOY_LOAD) lowload++;
         if (!JOY_CLK) run++;
         else if (run > 0) begin
            pulses++;
            if (run != CD) badw++;
            run = 0;
         end
      end while (!frame_stb && per < 2 * FP);
      chk("frame_period", 64'(per), 64'(FP));
      chk("load_low_clks", 64'(lowload), 64'(2 * CD));
      chk("clk_low_pulses", 64'(pulses), 64'd32);
      chk("clk_low_bad_width", 64'(badw), 64'd0);
      pat = 32'h0000_0000;
      wait_stb();
      chk("data0_j", {32'd0, joystick1, joystick2}, 64'h0);
      pat = 32'hFFFF_FFFF;
      wait_stb();
      chk("data1_j", {32'd0, joystick1, joystick2}, 64'h0);
      pat = 32'h0000_FFFE;
      wait_stb();
      chk("p2_disc_j", {32'd0, joystick1, joystick2}, 64'h0001_0000);
      for (int i = 0; i < 6; i++) begin
         rand_pat();
         wait_stb();
      end
      pat = 32'h5A5A_FF00;
      wait_stb();
      chk("pre_abort_j", {32'd0, joystick1, joystick2}, 64'h00FF_A5A5);
      pat = 32'h0F0F_3C3C;
      falls = 0; pc = JOY_CLK; per = 0;
      while (falls < 18 && per < 2 * FP) begin
         @(negedge clk);
         per++;
         if (pc && !JOY_CLK) falls++;
         pc = JOY_CLK;
      end
      chk("reach_bit17", 64'(falls), 64'd18);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 RESET_N = 1'b0;
      #1 chk("abort_outs", {29'd0, joystick1, joystick2, JOY_CLK, JOY_LOAD, frame_stb},
             {29'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0});
      pat = 32'h1234_ABCD;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 RESET_N = 1'b1;
      wait_stb();
      chk("post_abort_j", {32'd0, joystick1, joystick2}, 64'h5432_EDCB);
      rand_pat();
      wait_stb();
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
